// File: rtl/vector_operand_fetch_pkg.sv
// Shared types and constants for the vector operand fetch unit.
// Holds the FSM state encoding, the lane width and index-width helpers.
package vector_operand_fetch_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } vop_state_e;

  // Lane select width; at least one bit so single-lane builds stay legal.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? int'($clog2(lanes)) : 1;
  endfunction

  // Issue counter width, covering 0 .. 2*lanes-1.
  function automatic int unsigned issue_idx_w(input int unsigned lanes);
    return int'($clog2(2 * lanes));
  endfunction

endpackage

// File: rtl/vector_operand_fetch_if.sv
// Memory read port and operand handshake of the vector operand fetch unit.
// master = fetch unit, slave = memory plus downstream consumer.
interface vector_operand_fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANES  = 4
);
  import vector_operand_fetch_pkg::*;

  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [LANE_W-1:0]         mem_rdata;
  logic [LANE_W*LANES-1:0]   in1;
  logic [LANE_W*LANES-1:0]   in2;
  logic                      valid;
  logic                      ack;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    output in1,
    output in2,
    output valid,
    input  ack
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    input  in1,
    input  in2,
    input  valid,
    output ack
  );

endinterface

// File: rtl/vop_byte_gather.sv
// Packed LANES x 8-bit operand register, written one lane at a time.
// Synchronous active-low clear; unwritten lanes keep their previous value.
module vop_byte_gather
  import vector_operand_fetch_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter int unsigned LaneIdxW = lane_idx_w(LANES)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [LaneIdxW-1:0]     lane_i,
  input  logic [LANE_W-1:0]       data_i,
  output logic [LANE_W*LANES-1:0] vec_o
);

  logic [LANE_W*LANES-1:0] vec_d;
  logic [LANE_W*LANES-1:0] vec_q;

  always_comb begin
    vec_d = vec_q;
    if (we_i) begin
      vec_d[lane_i*LANE_W +: LANE_W] = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign vec_o = vec_q;

endmodule

// File: rtl/vector_operand_fetch.sv
// Gathers two packed LANES x 8-bit operands from byte-wide synchronous memory,
// one byte per cycle, and presents them with a valid/ack handshake.
module vector_operand_fetch
  import vector_operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANES  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [ADDR_W-1:0]    addr_b,
  output logic                 busy,
  vector_operand_fetch_if.master bus
);

  localparam int unsigned IdxW     = issue_idx_w(LANES);
  localparam int unsigned LaneIdxW = lane_idx_w(LANES);
  localparam logic [IdxW-1:0] LanesIdx = IdxW'(LANES);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(2 * LANES - 1);

  vop_state_e          state_q;
  logic [IdxW-1:0]     idx_q;
  logic [ADDR_W-1:0]   base_a_q;
  logic [ADDR_W-1:0]   base_b_q;
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                valid_q;

  logic [IdxW-1:0]     idx_inc;
  logic [ADDR_W-1:0]   next_addr;

  // Address for the following issue slot; wraps modulo 2**ADDR_W.
  always_comb begin
    idx_inc = idx_q + 1'b1;
    if (idx_inc < LanesIdx) begin
      next_addr = base_a_q + ADDR_W'(idx_inc);
    end else begin
      next_addr = base_b_q + ADDR_W'(idx_inc - LanesIdx);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_a_q   <= addr_a;
            base_b_q   <= addr_b;
            idx_q      <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr_a;
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          if (idx_q == LastIdx) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            state_q    <= StDrain;
          end else begin
            idx_q      <= idx_inc;
            mem_addr_q <= next_addr;
          end
        end
        StDrain: begin
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (bus.ack) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data trails its issue by one cycle: FETCH captures idx-1, DRAIN the last one.
  logic                cap_en;
  logic [IdxW-1:0]     cap_idx;
  logic                cap_is_a;
  logic [LaneIdxW-1:0] cap_lane;
  logic                we_a;
  logic                we_b;

  always_comb begin
    cap_en   = ((state_q == StFetch) && (idx_q != '0)) || (state_q == StDrain);
    cap_idx  = (state_q == StDrain) ? idx_q : idx_q - 1'b1;
    cap_is_a = cap_idx < LanesIdx;
    cap_lane = cap_is_a ? LaneIdxW'(cap_idx) : LaneIdxW'(cap_idx - LanesIdx);
    we_a     = cap_en && cap_is_a;
    we_b     = cap_en && !cap_is_a;
  end

  logic [LANE_W*LANES-1:0] vec_a;
  logic [LANE_W*LANES-1:0] vec_b;

  vop_byte_gather #(
    .LANES    (LANES),
    .LaneIdxW (LaneIdxW)
  ) u_gather_a (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (we_a),
    .lane_i (cap_lane),
    .data_i (bus.mem_rdata),
    .vec_o  (vec_a)
  );

  vop_byte_gather #(
    .LANES    (LANES),
    .LaneIdxW (LaneIdxW)
  ) u_gather_b (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (we_b),
    .lane_i (cap_lane),
    .data_i (bus.mem_rdata),
    .vec_o  (vec_b)
  );

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.in1      = vec_a;
  assign bus.in2      = vec_b;
  assign bus.valid    = valid_q;
  assign busy         = (state_q != StIdle);

endmodule
